// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2N-bit dividend / N-bit divisor, truncating toward zero.
// Restoring algorithm on magnitudes, sign fix-up and overflow detection in a final cycle.
module seq_signed_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   din,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           err
);

    localparam int CW = $clog2(2 * N);
    localparam logic [2*N-1:0] LIM_POS = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [2*N-1:0] LIM_NEG = LIM_POS + 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   dmag_q, dmag_d;
    logic           sgn_q_q, sgn_q_d;
    logic           sgn_r_q, sgn_r_d;
    logic           zflag_q, zflag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rmd_q, rmd_d;
    logic           err_q, err_d;

    logic [N:0]     shifted;
    logic           ovf;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        zflag_d = zflag_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        err_d   = err_q;

        // rem stays below |din| <= 2^(N-1), so its low N bits carry the full value
        shifted = {rem_q[N-1:0], dvd_q[2*N-1]};
        ovf     = sgn_q_q ? (dvd_q > LIM_NEG) : (dvd_q > LIM_POS);

        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (go) begin
                    dvd_d   = p[2*N-1] ? -p : p;
                    dmag_d  = din[N-1] ? -din : din;
                    sgn_q_d = p[2*N-1] ^ din[N-1];
                    sgn_r_d = p[2*N-1];
                    zflag_d = (din == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (shifted >= {1'b0, dmag_q}) begin
                    rem_d = shifted - {1'b0, dmag_q};
                    dvd_d = {dvd_q[2*N-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    dvd_d = {dvd_q[2*N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zflag_q || ovf) begin
                    err_d = 1'b1;
                    quo_d = '0;
                    rmd_d = '0;
                end else begin
                    err_d = 1'b0;
                    quo_d = sgn_q_q ? -dvd_q[N-1:0] : dvd_q[N-1:0];
                    rmd_d = sgn_r_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!go) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            zflag_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dmag_q  <= dmag_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            zflag_q <= zflag_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            err_q   <= err_d;
        end
    end

    assign done = done_q;
    assign q    = quo_q;
    assign r    = rmd_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: integer-arithmetic reference model checked on every
// done cycle, plus literal expectations for latency, handshake, boundaries and reset abort.
module tb_seq_signed_divider;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go;
    logic [15:0]       p;
    logic [7:0]        din;
    logic              done;
    logic [7:0]        q;
    logic [7:0]        r;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] op_p;
    logic signed [7:0]  op_d;
    bit                 model_on = 1'b0;

    seq_signed_divider #(.N(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (go),
        .p    (p),
        .din  (din),
        .done (done),
        .q    (q),
        .r    (r),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {err, q, r} from plain truncating integer division
    function automatic logic [16:0] model(input logic signed [15:0] pv, input logic signed [7:0] dv);
        int a;
        int b;
        int qi;
        int ri;
        a = pv;
        b = dv;
        if (b == 0) return {1'b1, 16'h0000};
        qi = a / b;
        ri = a % b;
        if (qi > 127 || qi < -128) return {1'b1, 16'h0000};
        return {1'b0, qi[7:0], ri[7:0]};
    endfunction

    always @(negedge clk) begin
        logic [16:0] m;
        if (model_on && done) begin
            m = model(op_p, op_d);
            chk("model_q", q, m[15:8]);
            chk("model_r", r, m[7:0]);
            chk("model_err", err, m[16]);
        end
    end

    // mode 0: go held; mode 1: operands change during RUN; mode 2: go low in RUN with one pulse
    task automatic run_op(input logic signed [15:0] pv, input logic signed [7:0] dv,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee,
                          input int hold, input int mode);
        int  edges;
        int  bad;
        bit  seen;
        @(negedge clk);
        p = pv;
        din = dv;
        go = 1'b1;
        op_p = pv;
        op_d = dv;
        model_on = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 seen = done;
        while (!seen && edges < 40) begin
            @(negedge clk);
            if (mode == 1 && edges == 3) begin
                p = 16'h1234;
                din = 8'h03;
            end
            if (mode == 2) begin
                if (edges == 1) go = 1'b0;
                if (edges == 5) go = 1'b1;
                if (edges == 6) go = 1'b0;
            end
            @(posedge clk);
            edges++;
            #1 seen = done;
        end
        chk("latency_edges", seen ? edges : -1, 18);
        chk("lit_q", q, eq);
        chk("lit_r", r, er);
        chk("lit_err", err, ee);
        if (mode != 2) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1 if (!done || q !== eq || r !== er || err !== ee) bad++;
            end
            chk("hold_stable", bad, 0);
            @(negedge clk);
            go = 1'b0;
            @(posedge clk);
            #1 chk("done_drop", done, 0);
            chk("q_kept", q, eq);
        end else begin
            @(posedge clk);
            #1 chk("done_drop", done, 0);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1 if (done) bad++;
            end
            chk("no_restart", bad, 0);
        end
        model_on = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        go = 1'b0;
        p = '0;
        din = '0;
        #23;
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        run_op(-16'sd200,   8'sd20,  8'hF6, 8'h00, 1'b0, 100, 0);
        run_op(-16'sd1003,  8'sd10,  8'h9C, 8'hFD, 1'b0, 1, 0);
        run_op(-16'sd1000, -8'sd60,  8'h10, 8'hD8, 1'b0, 1, 0);
        run_op(16'sd1000,   8'sd40,  8'h19, 8'h00, 1'b0, 1, 0);
        run_op(-16'sd1280,  8'sd10,  8'h80, 8'h00, 1'b0, 1, 0);
        run_op(16'sd1280,   8'sd10,  8'h00, 8'h00, 1'b1, 1, 0);
        run_op(16'sh8000,  -8'sd1,   8'h00, 8'h00, 1'b1, 1, 0);
        run_op(16'sd123,    8'sd0,   8'h00, 8'h00, 1'b1, 1, 0);
        run_op(16'sd7,      8'sd2,   8'h03, 8'h01, 1'b0, 1, 0);
        run_op(16'sd5000,   8'sd77,  8'h40, 8'h48, 1'b0, 3, 1);
        run_op(-16'sd300,   8'sd7,   8'hD6, 8'hFA, 1'b0, 0, 2);

        // abort mid-RUN with an asynchronous reset between edges
        @(negedge clk);
        p = 16'sd1000;
        din = 8'sd40;
        go = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_err", err, 0);
        go = 1'b0;
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (done) bad++;
        end
        chk("abort_no_result", bad, 0);

        run_op(-16'sd127,  -8'sh80,  8'h00, 8'h81, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
